// File: rtl/btn_gesture_decoder.sv
// -----------------------------------------------------------------------------
// btn_gesture_decoder
//
// Turns the debounced press/release pulses of a single button into clean,
// mutually exclusive gesture pulses for the RC car mode/speed control:
// a single click, a double click, a long press, and auto-repeat ticks while
// a long press is held. All timing is counted in clk cycles.
//
// Parameters:
//   LONG_CYCLES   - hold time that qualifies a press as long (>= 2)
//   GAP_CYCLES    - maximum release-to-press gap of a double click (>= 2)
//   REPEAT_CYCLES - auto-repeat period while a long press is held (>= 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_p      in   asynchronous active-high reset
//   btn_pe       in   one-cycle pulse, button pressed
//   btn_ne       in   one-cycle pulse, button released
//   short_press  out  one-cycle pulse, single click confirmed
//   double_click out  one-cycle pulse, second release of a double click
//   long_press   out  one-cycle pulse, hold reached LONG_CYCLES
//   repeat_tick  out  one-cycle pulse, every REPEAT_CYCLES while long-held
//   pressed      out  level, button currently considered held
// -----------------------------------------------------------------------------
module btn_gesture_decoder #(
  parameter int LONG_CYCLES   = 100_000_000,
  parameter int GAP_CYCLES    = 30_000_000,
  parameter int REPEAT_CYCLES = 20_000_000
) (
  input  logic clk,
  input  logic reset_p,
  input  logic btn_pe,
  input  logic btn_ne,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_tick,
  output logic pressed
);

  // The counter only has to reach (largest parameter - 1).
  localparam int MAX_LG     = (LONG_CYCLES > GAP_CYCLES) ? LONG_CYCLES : GAP_CYCLES;
  localparam int MAX_CYCLES = (MAX_LG > REPEAT_CYCLES) ? MAX_LG : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_TERM    = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRESSED1  = 3'd1;
  localparam logic [2:0] S_WAIT2     = 3'd2;
  localparam logic [2:0] S_PRESSED2  = 3'd3;
  localparam logic [2:0] S_LONG_HELD = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_q, short_d;
  logic             double_q, double_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;

  // A cycle carrying both pulses is ambiguous and is treated as no event.
  logic press_ev;
  logic release_ev;
  assign press_ev   = btn_pe & ~btn_ne;
  assign release_ev = btn_ne & ~btn_pe;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (press_ev) state_d = S_PRESSED1;
      end

      // Release beats the long-press terminal count in the same cycle.
      S_PRESSED1: begin
        if (release_ev) begin
          state_d = S_WAIT2;
        end else if (cnt_q == LONG_TERM) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end

      // A second press on the very last gap cycle still counts as a double.
      S_WAIT2: begin
        if (press_ev) begin
          state_d = S_PRESSED2;
        end else if (cnt_q == GAP_TERM) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end

      // Holding the second press into a long press drops the first click.
      S_PRESSED2: begin
        if (release_ev) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end else if (cnt_q == LONG_TERM) begin
          state_d = S_LONG_HELD;
          long_d  = 1'b1;
        end
      end

      S_LONG_HELD: begin
        if (release_ev) begin
          state_d = S_IDLE;
        end else if (cnt_q == REPEAT_TERM) begin
          repeat_d = 1'b1;
          cnt_d    = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every state change restarts timing; IDLE has no deadline, so the
    // counter simply rests at zero there instead of running freely.
    if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      double_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      double_q <= double_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
    end
  end

  assign short_press  = short_q;
  assign double_click = double_q;
  assign long_press   = long_q;
  assign repeat_tick  = repeat_q;
  assign pressed      = (state_q == S_PRESSED1) || (state_q == S_PRESSED2) ||
                        (state_q == S_LONG_HELD);

endmodule

// File: tb/tb_btn_gesture_decoder.sv
// -----------------------------------------------------------------------------
// tb_btn_gesture_decoder
//
// Drives btn_gesture_decoder with directed gesture scenarios followed by
// randomized button activity. A deadline-based reference model predicts the
// output vector of every cycle; a monitor compares the DUT against the queued
// predictions, and per-scenario pulse logs are checked against fixed cycle
// numbers.
// -----------------------------------------------------------------------------
module tb_btn_gesture_decoder;

  localparam int L = 20;
  localparam int G = 8;
  localparam int R = 5;

  logic clk = 1'b0;
  logic reset_p = 1'b0;
  logic btn_pe = 1'b0;
  logic btn_ne = 1'b0;
  logic short_press, double_click, long_press, repeat_tick, pressed;

  btn_gesture_decoder #(
    .LONG_CYCLES  (L),
    .GAP_CYCLES   (G),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .btn_pe      (btn_pe),
    .btn_ne      (btn_ne),
    .short_press (short_press),
    .double_click(double_click),
    .long_press  (long_press),
    .repeat_tick (repeat_tick),
    .pressed     (pressed)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  // Expected output vector {short, double, long, repeat, pressed} tagged with
  // the cycle in which it must be visible.
  typedef struct packed {
    int         cyc;
    logic [4:0] v;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  // Pulse logs kept by the monitor, read by the directed scenarios.
  int   n_short = 0, n_double = 0, n_long = 0, n_repeat = 0, n_pressed = 0;
  int   last_short = -1, last_double = -1, last_long = -1, last_repeat = -1;
  int   last_pressed = -1, last_rise = -1;
  logic prev_pressed = 1'b0;

  // Reference model: tracks whether the button is held, how many clicks the
  // current interaction has, and absolute deadlines for pending pulses.
  bit m_held = 0, m_long = 0, m_short_pend = 0;
  int m_clicks = 0, m_long_due = 0, m_rep_due = 0, m_short_due = 0;

  int pe_at[$];
  int ne_at[$];
  int rst_at[$];

  // Clears the model as an asynchronous reset would.
  task automatic modelReset();
    m_held = 0; m_long = 0; m_short_pend = 0;
    m_clicks = 0; m_long_due = 0; m_rep_due = 0; m_short_due = 0;
  endtask

  // Given the inputs sampled at the end of cycle t, returns the outputs
  // expected during cycle t+1.
  task automatic modelStep(input int t, input logic pe_in, input logic ne_in,
                           output logic [4:0] e);
    logic pe, ne;
    pe = pe_in & ~ne_in;
    ne = ne_in & ~pe_in;
    e  = '0;
    if (m_held && !m_long) begin
      if (ne) begin
        m_held = 0;
        if (m_clicks == 1) begin
          m_short_pend = 1;
          m_short_due  = t + G + 1;
        end else begin
          e[3] = 1'b1;
          m_clicks = 0;
        end
      end else if (t + 1 == m_long_due) begin
        e[2] = 1'b1;
        m_long = 1;
        m_clicks = 0;
        m_rep_due = t + 1 + R;
      end
    end else if (m_held) begin
      if (ne) begin
        m_held = 0;
        m_long = 0;
      end else if (t + 1 == m_rep_due) begin
        e[1] = 1'b1;
        m_rep_due = m_rep_due + R;
      end
    end else if (m_short_pend) begin
      if (pe) begin
        m_short_pend = 0;
        m_held = 1;
        m_clicks = 2;
        m_long_due = t + L + 1;
      end else if (t + 1 == m_short_due) begin
        e[4] = 1'b1;
        m_short_pend = 0;
        m_clicks = 0;
      end
    end else if (pe) begin
      m_held = 1;
      m_clicks = 1;
      m_long_due = t + L + 1;
    end
    e[0] = m_held;
  endtask

  // One counted comparison with a FAIL line on disagreement.
  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Advances one cycle, drives the inputs and queues the model's prediction.
  // While reset is high the outputs must already be zero in this cycle.
  task automatic applyStimulus(input logic pe, input logic ne, input logic rst);
    logic [4:0] e;
    exp_t item;
    @(posedge clk);
    #1;
    cyc++;
    reset_p = rst;
    btn_pe  = pe;
    btn_ne  = ne;
    if (rst) begin
      modelReset();
      foreach (sb_q[i]) if (sb_q[i].cyc == cyc) sb_q[i].v = '0;
      item.cyc = cyc + 1;
      item.v   = '0;
      sb_q.push_back(item);
      #1;
      checkOutput("reset_outputs_zero",
                  int'({short_press, double_click, long_press, repeat_tick, pressed}), 0);
    end else begin
      modelStep(cyc, pe, ne, e);
      item.cyc = cyc + 1;
      item.v   = e;
      sb_q.push_back(item);
    end
  endtask

  // Compares the DUT against the queued prediction each cycle and logs pulses.
  task automatic monitor();
    logic [4:0] act;
    exp_t       item;
    forever begin
      @(negedge clk);
      act = {short_press, double_click, long_press, repeat_tick, pressed};
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        item = sb_q.pop_front();
        checkOutput("stale_prediction_cycle", item.cyc, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        item = sb_q.pop_front();
        compared++;
        if (act !== item.v) begin
          mismatched++;
          $display("[TB] FAIL outputs@%0d: got %b, expected %b (short,double,long,repeat,pressed)",
                   cyc, act, item.v);
        end
      end
      if (short_press === 1'b1)  begin n_short++;  last_short  = cyc; end
      if (double_click === 1'b1) begin n_double++; last_double = cyc; end
      if (long_press === 1'b1)   begin n_long++;   last_long   = cyc; end
      if (repeat_tick === 1'b1)  begin n_repeat++; last_repeat = cyc; end
      if (pressed === 1'b1) begin
        n_pressed++;
        last_pressed = cyc;
        if (prev_pressed !== 1'b1) last_rise = cyc;
      end
      prev_pressed = pressed;
    end
  endtask

  function automatic bit inQ(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Resets the DUT, then plays pe_at/ne_at/rst_at at cycles relative to the
  // scenario origin t0 (cycle numbers match the plan's absolute numbering).
  int t0;
  int b_short, b_double, b_long, b_repeat, b_pressed;

  task automatic runScenario(input int n);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    t0 = cyc;
    b_short = n_short; b_double = n_double; b_long = n_long;
    b_repeat = n_repeat; b_pressed = n_pressed;
    for (int r = 1; r <= n; r++)
      applyStimulus(inQ(pe_at, r), inQ(ne_at, r), inQ(rst_at, r));
    @(negedge clk);
    #1;
  endtask

  // Directed scenarios, then randomized gestures, then the summary.
  initial begin
    int hold;
    int gap;
    int sel;
    fork
      monitor();
    join_none

    // Short press
    pe_at = {10}; ne_at = {15}; rst_at.delete();
    runScenario(40);
    checkOutput("short_count",     n_short - b_short, 1);
    checkOutput("short_cycle",     last_short - t0, 24);
    checkOutput("short_pressed_n", n_pressed - b_pressed, 5);
    checkOutput("short_pressed_rise", last_rise - t0, 11);
    checkOutput("short_other_pulses", (n_double - b_double) + (n_long - b_long) + (n_repeat - b_repeat), 0);

    // Long press with repeat
    pe_at = {10}; ne_at = {50}; rst_at.delete();
    runScenario(70);
    checkOutput("long_count",        n_long - b_long, 1);
    checkOutput("long_cycle",        last_long - t0, 31);
    checkOutput("long_repeat_count", n_repeat - b_repeat, 3);
    checkOutput("long_repeat_last",  last_repeat - t0, 46);
    checkOutput("long_pressed_last", last_pressed - t0, 50);
    checkOutput("long_no_short",     n_short - b_short, 0);

    // Double click
    pe_at = {10, 17}; ne_at = {13, 20}; rst_at.delete();
    runScenario(50);
    checkOutput("double_count",    n_double - b_double, 1);
    checkOutput("double_cycle",    last_double - t0, 21);
    checkOutput("double_no_short", n_short - b_short, 0);
    checkOutput("double_no_long",  n_long - b_long, 0);

    // Gap boundary: press on the last gap cycle wins
    pe_at = {10, 21}; ne_at = {13}; rst_at.delete();
    runScenario(30);
    checkOutput("gap_press_no_short",  n_short - b_short, 0);
    checkOutput("gap_press_pressed_n", n_pressed - b_pressed, 12);

    // Gap boundary: timeout wins, then a fresh press
    pe_at = {10, 22}; ne_at = {13}; rst_at.delete();
    runScenario(30);
    checkOutput("gap_timeout_short_count", n_short - b_short, 1);
    checkOutput("gap_timeout_short_cycle", last_short - t0, 22);
    checkOutput("gap_timeout_new_press",   last_rise - t0, 23);

    // Reset during LONG_HELD, then a lone release
    pe_at = {10}; ne_at = {40}; rst_at = {33, 34};
    runScenario(60);
    checkOutput("rst_long_count",    n_long - b_long, 1);
    checkOutput("rst_no_repeat",     n_repeat - b_repeat, 0);
    checkOutput("rst_pressed_last",  last_pressed - t0, 32);
    checkOutput("rst_no_short",      n_short - b_short, 0);

    // Simultaneous press and release in IDLE
    pe_at = {10}; ne_at = {10}; rst_at.delete();
    runScenario(50);
    checkOutput("both_no_pressed", n_pressed - b_pressed, 0);
    checkOutput("both_no_pulses",
                (n_short - b_short) + (n_double - b_double) + (n_long - b_long) + (n_repeat - b_repeat), 0);

    // Randomized gestures with occasional noise, glitches and resets
    applyStimulus(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 160; k++) begin
      hold = $urandom_range(1, 40);
      gap  = $urandom_range(1, 12);
      sel  = $urandom_range(0, 19);
      if (sel == 0) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
      end else if (sel == 1) begin
        applyStimulus(1'b0, 1'b1, 1'b0);
      end else if (sel == 2) begin
        applyStimulus(1'b1, 1'b1, 1'b0);
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int h = 1; h < hold; h++)
          applyStimulus($urandom_range(0, 9) == 0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        for (int g = 0; g < gap; g++)
          applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
    for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
